uart_msg_arbiter: RTL

Shares one UART transmit FIFO between `N_REQ` message requesters. Each requester asks for a whole message, given as a start address and byte length in a shared message ROM. The arbiter grants requesters round-robin, one full message at a time. It fetches the bytes from the ROM and pushes them into the FIFO write port, honouring `fifo_full`. It sits between the message sources (button, status, heartbeat logic) and the uart_fifo/uart_tx pair.

---
 rtl/uart_msg_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/uart_msg_arbiter.sv
// uart_msg_arbiter: round-robin arbiter that streams whole messages from a
// shared message ROM into a UART transmit FIFO, one requester at a time.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | wait for a request; pick next requester and latch its message
// S_FETCH | present the address counter to the ROM
// S_WAIT  | ROM data arrives; capture it into fifo_data
// S_WRITE | push fifo_data when the FIFO has room; advance the counters
// S_DONE  | pulse done for the granted requester and remember it as last
module uart_msg_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 8
) (
  input  logic                    CLK,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] base,
  input  logic [N_REQ*8-1:0]      len,
  output logic [N_REQ-1:0]        done,
  output logic                    busy,
  output logic [2:0]              grant,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [7:0]              mem_data,
  output logic [7:0]              fifo_data,
  output logic                    fifo_wr,
  input  logic                    fifo_full
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state;
  logic [2:0]        last;
  logic [2:0]        sel;
  logic              sel_vld;
  logic [ADDR_W-1:0] sel_base;
  logic [7:0]        sel_len;
  logic [ADDR_W-1:0] addr_cnt;
  logic [7:0]        remain;
  logic              wr_ok;

  // Round-robin pick: first set request bit scanning upward from last+1.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!sel_vld && req[i] && (i == (int'(last) + k) % N_REQ)) begin
          sel_vld = 1'b1;
          sel     = 3'(i);
        end
      end
    end
  end

  assign sel_base = base[int'(sel)*ADDR_W +: ADDR_W];
  assign sel_len  = len[int'(sel)*8 +: 8];

  // A write is only taken when the FIFO has room; reset suppresses it at once.
  assign wr_ok    = (state == S_WRITE) && !fifo_full;
  assign fifo_wr  = wr_ok && !rst;
  assign busy     = (state != S_IDLE);
  assign mem_addr = addr_cnt;

  // One-hot done pulse for the granted requester while in DONE.
  always_comb begin
    done = '0;
    for (int i = 0; i < N_REQ; i++) begin
      done[i] = (state == S_DONE) && !rst && (int'(grant) == i);
    end
  end

  // Message sequencing: latch the grant, then fetch/wait/write per byte.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state     <= S_IDLE;
      last      <= 3'(N_REQ - 1);
      grant     <= '0;
      addr_cnt  <= '0;
      remain    <= '0;
      fifo_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (sel_vld) begin
            grant    <= sel;
            addr_cnt <= sel_base;
            remain   <= sel_len;
            state    <= (sel_len == 8'd0) ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: state <= S_WAIT;
        S_WAIT: begin
          fifo_data <= mem_data;
          state     <= S_WRITE;
        end
        S_WRITE: begin
          if (wr_ok) begin
            remain   <= remain - 8'd1;
            addr_cnt <= addr_cnt + 1'b1;
            state    <= (remain == 8'd1) ? S_DONE : S_FETCH;
          end
        end
        S_DONE: begin
          last  <= grant;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
